viterbi_dec_param: RTL and testbench

Parametrised hard-decision Viterbi decoder for rate-1/2 convolutional codes, sitting directly after the symbol slicer in the receive path. It supports constraint length K = 3..6, generator polynomials as parameters, and register-exchange survivor memory of depth D. It replaces the fixed K=3 decoder. New capabilities are valid/ready flow control, frame termination with drain, and path-metric normalisation.

---
 rtl/viterbi_pkg.sv | 40 ++++
 rtl/viterbi_acs.sv | 57 +++++
 rtl/viterbi_dec_param.sv | 214 +++++++++++++++++++++
 tb/tb_viterbi_dec_param.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared types, limits and helper functions
// for the parametrised hard-decision Viterbi decoder.
package viterbi_pkg;

    localparam int K_MIN    = 3;
    localparam int K_MAX    = 6;
    localparam int D_MIN    = 2;
    localparam int PM_W_MIN = 3;
    localparam int PM_W_MAX = 16;

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_DRAIN = 1'b1
    } vit_state_e;

    function automatic logic parity(input logic [K_MAX-1:0] v);
        return ^v;
    endfunction

    // Hamming distance between received and expected symbol
    function automatic logic [1:0] branch_metric(
        input logic [1:0] rx,
        input logic [1:0] ex
    );
        logic [1:0] d;
        d = rx ^ ex;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction

    function automatic bit cfg_ok(
        input int k,
        input int d,
        input int pm_w
    );
        return (k >= K_MIN) && (k <= K_MAX) &&
               (d >= D_MIN) &&
               (pm_w >= PM_W_MIN) && (pm_w <= PM_W_MAX);
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// viterbi_acs: add-compare-select plus register-exchange
// survivor update for one next state NS_IDX.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int K      = 3,
    parameter int G0     = 'b111,
    parameter int G1     = 'b101,
    parameter int D      = 15,
    parameter int PM_W   = 6,
    parameter int NS_IDX = 0
) (
    input  logic [1:0]      i_sym,
    input  logic [PM_W-1:0] i_pm0,
    input  logic [PM_W-1:0] i_pm1,
    input  logic [D-2:0]    i_surv0,
    input  logic [D-2:0]    i_surv1,
    output logic [PM_W-1:0] o_pm,
    output logic [D-1:0]    o_surv
);

    localparam int NS = 1 << (K - 1);
    localparam int U  = (NS_IDX >> (K - 2)) & 1;
    localparam int P0 = (NS_IDX << 1) & (NS - 1);
    localparam int P1 = P0 | 1;
    localparam int W0 = (U << (K - 1)) | P0;
    localparam int W1 = (U << (K - 1)) | P1;

    localparam logic U_BIT = 1'(U);
    localparam logic [1:0] E0 = {parity(K_MAX'(W0 & G0)),
                                 parity(K_MAX'(W0 & G1))};
    localparam logic [1:0] E1 = {parity(K_MAX'(W1 & G0)),
                                 parity(K_MAX'(W1 & G1))};
    localparam logic [PM_W-1:0] PM_MAX = '1;

    logic [1:0]      w_bm0;
    logic [1:0]      w_bm1;
    logic [PM_W:0]   w_sum0;
    logic [PM_W:0]   w_sum1;
    logic [PM_W-1:0] w_c0;
    logic [PM_W-1:0] w_c1;
    logic            w_sel;

    // saturating add, keep lower candidate, tie goes to pred LSB 0
    always_comb begin
        w_bm0  = branch_metric(i_sym, E0);
        w_bm1  = branch_metric(i_sym, E1);
        w_sum0 = {1'b0, i_pm0} + {{(PM_W-1){1'b0}}, w_bm0};
        w_sum1 = {1'b0, i_pm1} + {{(PM_W-1){1'b0}}, w_bm1};
        w_c0   = w_sum0[PM_W] ? PM_MAX : w_sum0[PM_W-1:0];
        w_c1   = w_sum1[PM_W] ? PM_MAX : w_sum1[PM_W-1:0];
        w_sel  = (w_c1 < w_c0);
        o_pm   = w_sel ? w_c1 : w_c0;
        o_surv = w_sel ? {i_surv1, U_BIT} : {i_surv0, U_BIT};
    end

endmodule

// File: rtl/viterbi_dec_param.sv
// viterbi_dec_param: rate-1/2 hard-decision Viterbi decoder with
// register-exchange survivors, flow control and frame drain.
module viterbi_dec_param
    import viterbi_pkg::*;
#(
    parameter int K    = 3,
    parameter int G0   = 'b111,
    parameter int G1   = 'b101,
    parameter int D    = 15,
    parameter int PM_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_sym,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    output logic            out_last,
    output logic [PM_W-1:0] best_metric
);

    localparam int NS = 1 << (K - 1);
    localparam int SW = K - 1;
    localparam int CW = $clog2(D + 1);
    localparam int DW = $clog2(D);

    localparam logic [PM_W-1:0] PM_MAX   = '1;
    localparam logic [CW-1:0]   CNT_MAX  = CW'(D);
    localparam logic [CW-1:0]   CNT_EMIT = CW'(D - 1);
    localparam logic [DW-1:0]   DRN_MAX  = DW'(D - 1);

    if (!cfg_ok(K, D, PM_W)) begin : g_cfg_err
        $error("viterbi_dec_param: illegal K, D or PM_W");
    end

    vit_state_e      r_state;
    vit_state_e      w_state_nxt;

    logic [PM_W-1:0] r_pm       [NS];
    logic [D-2:0]    r_surv     [NS];
    logic [PM_W-1:0] w_pm_new   [NS];
    logic [D-1:0]    w_surv_new [NS];

    logic [PM_W-1:0] w_min;
    logic [SW-1:0]   w_best;
    logic [D-1:0]    w_best_surv;

    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_new;
    logic [DW-1:0]   r_drn;
    logic [DW-1:0]   w_drain_n;
    logic [D-2:0]    r_drain;
    logic [PM_W-1:0] r_best_metric;
    logic [PM_W:0]   w_bm_sum;

    logic            r_out_valid;
    logic            r_out_bit;
    logic            r_out_last;

    logic            w_acc;
    logic            w_last_acc;
    logic            w_out_hs;
    logic            w_emit;
    logic            w_done;
    logic            w_reinit;
    logic            w_drain_ld;

    for (genvar g = 0; g < NS; g++) begin : g_acs
        localparam int P0 = (g * 2) % NS;
        viterbi_acs #(
            .K      (K),
            .G0     (G0),
            .G1     (G1),
            .D      (D),
            .PM_W   (PM_W),
            .NS_IDX (g)
        ) u_acs (
            .i_sym   (in_sym),
            .i_pm0   (r_pm[P0]),
            .i_pm1   (r_pm[P0+1]),
            .i_surv0 (r_surv[P0]),
            .i_surv1 (r_surv[P0+1]),
            .o_pm    (w_pm_new[g]),
            .o_surv  (w_surv_new[g])
        );
    end

    // best state: strict compare keeps the lowest index on ties
    always_comb begin
        w_min  = w_pm_new[0];
        w_best = '0;
        for (int i = 1; i < NS; i++) begin
            if (w_pm_new[i] < w_min) begin
                w_min  = w_pm_new[i];
                w_best = SW'(i);
            end
        end
    end

    assign w_best_surv = w_surv_new[w_best];

    // handshakes, symbol count and drain length
    always_comb begin
        w_acc      = in_valid && in_ready;
        w_last_acc = w_acc && in_last;
        w_out_hs   = r_out_valid && out_ready;
        w_emit     = (r_cnt >= CNT_EMIT);
        w_cnt_new  = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CW'(1);
        w_drain_n  = (w_cnt_new > CNT_EMIT) ? DRN_MAX : DW'(w_cnt_new);
        w_done     = (r_state == ST_DRAIN) && w_out_hs && r_out_last;
        w_reinit   = w_done || (w_last_acc && (w_drain_n == '0));
        w_drain_ld = (r_state == ST_DRAIN) &&
                     (!r_out_valid || out_ready) && (r_drn != '0);
        w_bm_sum   = {1'b0, r_best_metric} + {1'b0, w_min};
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_ACC;
        else        r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC:
                if (w_last_acc && (w_drain_n != '0))
                    w_state_nxt = ST_DRAIN;
            ST_DRAIN:
                if (w_done)
                    w_state_nxt = ST_ACC;
        endcase
    end

    // FSM outputs: input accepted only in ACC with a free out register
    always_comb begin
        in_ready = rst_n && (r_state == ST_ACC) &&
                   (!r_out_valid || out_ready);
    end

    // path metrics (normalised), survivors, counters, drain buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                r_pm[i]   <= (i == 0) ? '0 : PM_MAX;
                r_surv[i] <= '0;
            end
            r_cnt         <= '0;
            r_best_metric <= '0;
            r_drain       <= '0;
            r_drn         <= '0;
        end else if (w_reinit) begin
            for (int i = 0; i < NS; i++) begin
                r_pm[i]   <= (i == 0) ? '0 : PM_MAX;
                r_surv[i] <= '0;
            end
            r_cnt         <= '0;
            r_best_metric <= '0;
            r_drn         <= '0;
        end else begin
            if (w_acc) begin
                for (int i = 0; i < NS; i++) begin
                    r_pm[i]   <= w_pm_new[i] - w_min;
                    r_surv[i] <= w_surv_new[i][D-2:0];
                end
                r_cnt         <= w_cnt_new;
                r_best_metric <= w_bm_sum[PM_W] ? PM_MAX
                                                : w_bm_sum[PM_W-1:0];
                if (in_last) begin
                    r_drain <= w_best_surv[D-2:0];
                    r_drn   <= w_drain_n;
                end
            end
            if (w_drain_ld)
                r_drn <= r_drn - DW'(1);
        end
    end

    // output register: decided bit in ACC, buffered bits in DRAIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (r_state == ST_ACC) begin
            if (w_acc && w_emit) begin
                r_out_valid <= 1'b1;
                r_out_bit   <= w_best_surv[D-1];
                r_out_last  <= 1'b0;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end else begin
            if (w_done) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else if (w_drain_ld) begin
                r_out_valid <= 1'b1;
                r_out_bit   <= r_drain[r_drn - DW'(1)];
                r_out_last  <= (r_drn == DW'(1));
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_bit     = r_out_bit;
    assign out_last    = r_out_last;
    assign best_metric = r_best_metric;

endmodule

// File: tb/tb_viterbi_dec_param.sv
// tb_viterbi_dec_param: directed frames against a K=3 (7,5) D=15
// decoder and a K=5 (23,35) D=30 decoder.
`timescale 1ns/1ps
module tb_viterbi_dec_param;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       sel       = 1'b0;
    logic       in_valid  = 1'b0;
    logic [1:0] in_sym    = 2'b00;
    logic       in_last   = 1'b0;
    logic       out_ready = 1'b1;

    logic       v3, rdy3, ov3, ob3, ol3;
    logic       v5, rdy5, ov5, ob5, ol5;
    logic [5:0] bm3, bm5;

    logic       m_rdy, m_ov, m_ob, m_ol;
    logic [5:0] m_bm;

    assign v3    = in_valid && !sel;
    assign v5    = in_valid && sel;
    assign m_rdy = sel ? rdy5 : rdy3;
    assign m_ov  = sel ? ov5  : ov3;
    assign m_ob  = sel ? ob5  : ob3;
    assign m_ol  = sel ? ol5  : ol3;
    assign m_bm  = sel ? bm5  : bm3;

    viterbi_dec_param #(
        .K(3), .G0('b111), .G1('b101), .D(15), .PM_W(6)
    ) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (v3),
        .in_ready    (rdy3),
        .in_sym      (in_sym),
        .in_last     (in_last),
        .out_valid   (ov3),
        .out_ready   (out_ready),
        .out_bit     (ob3),
        .out_last    (ol3),
        .best_metric (bm3)
    );

    viterbi_dec_param #(
        .K(5), .G0('b10011), .G1('b11101), .D(30), .PM_W(6)
    ) u_dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (v5),
        .in_ready    (rdy5),
        .in_sym      (in_sym),
        .in_last     (in_last),
        .out_valid   (ov5),
        .out_ready   (out_ready),
        .out_bit     (ob5),
        .out_last    (ol5),
        .best_metric (bm5)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic       q_bits[$];
    logic       q_last[$];
    int         n_acc;
    int         first_at;
    bit         got_first;
    int         n_stall;
    logic [5:0] bm_last;
    bit         prev_stall = 1'b0;
    logic       prev_bit   = 1'b0;

    localparam logic [63:0] D40 = 64'h0000_00B4_6D29_F35C;
    localparam logic [63:0] D20 = 64'h0000_0000_0009_C6A3;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // output monitor and stall checks, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", 64'(m_ov), 64'd1);
                check("hold_bit", 64'(m_ob), 64'(prev_bit));
            end
            if (m_ov && !out_ready) begin
                check("stall_in_ready", 64'(m_rdy), 64'd0);
                n_stall++;
            end
            if (m_ov && !got_first) begin
                got_first = 1'b1;
                first_at  = n_acc;
            end
            if (m_ov && out_ready) begin
                q_bits.push_back(m_ob);
                q_last.push_back(m_ol);
                if (m_ol) bm_last = m_bm;
            end
            if (in_valid && m_rdy) n_acc++;
            prev_stall = m_ov && !out_ready;
            prev_bit   = m_ob;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_mon();
        q_bits.delete();
        q_last.delete();
        n_acc     = 0;
        first_at  = -1;
        got_first = 1'b0;
        n_stall   = 0;
        bm_last   = 6'h3f;
    endtask

    task automatic send_sym(input logic [1:0] s, input logic last);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_sym   = s;
        in_last  = last;
        @(negedge clk);
        while (!m_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!m_rdy) check("in_timeout", 64'(m_rdy), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // encoder model: w = {u, s}, next state {u, s[K-2:1]}
    task automatic send_frame(input int k, input int g0, input int g1,
                              input int n, input logic [63:0] data,
                              input int flip);
        int st;
        st = 0;
        for (int i = 0; i < n; i++) begin
            logic       u;
            logic [1:0] s;
            int         w;
            u = data[i];
            w = (int'(u) << (k - 1)) | st;
            s = {^(w & g0), ^(w & g1)};
            if (i == flip) s[0] = ~s[0];
            st = (int'(u) << (k - 2)) | (st >> 1);
            send_sym(s, i == n - 1);
        end
    endtask

    task automatic wait_last(input string tag);
        int n;
        n = 0;
        while (!(q_last.size() != 0 && q_last[$]) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done"},
              64'(q_last.size() != 0 && q_last[$]), 64'd1);
    endtask

    task automatic check_frame(input string tag, input int n,
                               input logic [63:0] exp,
                               input logic [5:0] exp_bm);
        logic [63:0] ob;
        logic [63:0] ol;
        ob = '0;
        ol = '0;
        for (int i = 0; i < q_bits.size() && i < 64; i++) begin
            ob[i] = q_bits[i];
            ol[i] = q_last[i];
        end
        check({tag, "_count"}, 64'(q_bits.size()), 64'(n));
        check({tag, "_bits"}, ob, exp);
        check({tag, "_last"}, ol, 64'd1 << (n - 1));
        check({tag, "_best_metric"}, 64'(bm_last), 64'(exp_bm));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(rdy3), 64'd0);
        check("rst_out_valid", 64'(ov3), 64'd0);
        check("rst_out_bit", 64'(ob3), 64'd0);
        check("rst_out_last", 64'(ol3), 64'd0);
        check("rst_best_metric", 64'(bm3), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(rdy3), 64'd1);

        // short frame drained entirely: 1,0,1,1
        clear_mon();
        send_sym(2'b11, 1'b0);
        send_sym(2'b10, 1'b0);
        send_sym(2'b00, 1'b0);
        send_sym(2'b01, 1'b1);
        wait_last("t1");
        check_frame("t1", 4, 64'b1101, 6'd0);

        // 40-bit error-free frame
        clear_mon();
        send_frame(3, 'b111, 'b101, 40, D40, -1);
        wait_last("t2");
        check_frame("t2", 40, D40, 6'd0);
        check("t2_first_latency", 64'(first_at), 64'd15);

        // same frame, one flipped bit at symbol 10
        clear_mon();
        send_frame(3, 'b111, 'b101, 40, D40, 10);
        wait_last("t3");
        check_frame("t3", 40, D40, 6'd1);

        // out_ready low for 5 cycles mid-frame
        clear_mon();
        fork
            send_frame(3, 'b111, 'b101, 40, D40, -1);
            begin
                for (int i = 0; i < 500 && n_acc < 20; i++)
                    @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_last("t4");
        check_frame("t4", 40, D40, 6'd0);
        check("t4_stall_cycles", 64'(n_stall), 64'd5);

        // reset during DRAIN, then a clean 20-symbol frame
        out_ready = 1'b0;
        clear_mon();
        send_sym(2'b11, 1'b0);
        send_sym(2'b10, 1'b0);
        send_sym(2'b00, 1'b0);
        send_sym(2'b01, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t5_drain_valid", 64'(ov3), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", 64'(ov3), 64'd0);
        check("t5_rst_in_ready", 64'(rdy3), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        clear_mon();
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_stray_output", 64'(q_bits.size()), 64'd0);
        clear_mon();
        send_frame(3, 'b111, 'b101, 20, D20, -1);
        wait_last("t5");
        check_frame("t5", 20, D20, 6'd0);

        // K=5 decoder, 60 zero symbols
        sel = 1'b1;
        clear_mon();
        send_frame(5, 'b10011, 'b11101, 60, 64'd0, -1);
        wait_last("t6");
        check_frame("t6", 60, 64'd0, 6'd0);
        check("t6_first_latency", 64'(first_at), 64'd30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
